dyn_phase_sweep: RTL and testbench

Phase-training sweep controller on the CLK50M domain, directly upstream of the PLL dynamic-phase stepper. On START it steps the selected PLL counter through NSTEPS phase positions, qualifies each position with an external SAMPLE_OK pass/fail signal, and finds the longest contiguous passing window. It then steps back down to the window centre and reports the result. Each phase step is issued to the stepper as a request and completes when the stepper returns a completion pulse; the stepper drives PHASESTEP/PHASEUPDOWN/PHASEDONE to the PLL.

---
 rtl/dyn_phase_pkg.sv | 40 ++++
 rtl/dyn_phase_window.sv | 60 ++++++
 rtl/dyn_phase_sweep.sv | 276 +++++++++++++++++++++++++++
 tb/tb_dyn_phase_sweep.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_phase_pkg.sv
// dyn_phase_pkg
// Shared definitions for the PLL dynamic-phase sweep controller:
//   - sweep_state_t : sweep FSM state encoding
//   - STEP_TIMEOUT  : cycles allowed for one phase step before abort
//                     (used only when DYN_PHASE_STEP_TIMEOUT_EN is defined)
//   - CNT_SEL_*     : PLL counter-select encodings for the stepper
//   - centre_pos()  : floor centre of a window given its start and length
package dyn_phase_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_STEP,
        S_STEPWAIT,
        S_CALC,
        S_RETURN,
        S_RETWAIT,
        S_FINISH
    } sweep_state_t;

    localparam int STEP_TIMEOUT = 1024;
    localparam int WD_W         = 10;

    localparam logic [3:0] CNT_SEL_ALL = 4'h0;
    localparam logic [3:0] CNT_SEL_M   = 4'h1;
    localparam logic [3:0] CNT_SEL_C0  = 4'h2;
    localparam logic [3:0] CNT_SEL_C1  = 4'h3;
    localparam logic [3:0] CNT_SEL_C2  = 4'h4;
    localparam logic [3:0] CNT_SEL_C3  = 4'h5;
    localparam logic [3:0] CNT_SEL_C4  = 4'h6;

    // Centre rounds down, so an even-length window picks its lower middle.
    function automatic logic [7:0] centre_pos(input logic [7:0] start,
                                              input logic [7:0] len);
        return start + ((len - 8'd1) >> 1);
    endfunction

endpackage

// File: rtl/dyn_phase_window.sv
// dyn_phase_window
// Tracks the current run of passing phase positions and the longest run
// seen so far during one sweep.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   clear             zero all run registers (start of a sweep)
//   eval              one-cycle strobe: fold 'pass' for position 'pos'
//   pass              1 = position passed qualification
//   pos               position being evaluated
//   best_start        first position of the longest passing window
//   best_len          length of that window (0 = nothing passed)
module dyn_phase_window
    import dyn_phase_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       eval,
    input  logic       pass,
    input  logic [7:0] pos,
    output logic [7:0] best_start,
    output logic [7:0] best_len
);

    logic [7:0] cur_start;
    logic [7:0] cur_len;
    logic [7:0] run_start;
    logic [7:0] run_len;

    // A run begins at the current position when no run is open.
    assign run_start = (cur_len == 8'd0) ? pos : cur_start;
    assign run_len   = cur_len + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_start  <= 8'd0;
            cur_len    <= 8'd0;
            best_start <= 8'd0;
            best_len   <= 8'd0;
        end else if (clear) begin
            cur_start  <= 8'd0;
            cur_len    <= 8'd0;
            best_start <= 8'd0;
            best_len   <= 8'd0;
        end else if (eval) begin
            if (pass) begin
                cur_start <= run_start;
                cur_len   <= run_len;
                // Strictly longer only: on a tie the earlier window is kept.
                if (run_len > best_len) begin
                    best_start <= run_start;
                    best_len   <= run_len;
                end
            end else begin
                cur_len <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/dyn_phase_sweep.sv
// dyn_phase_sweep
// Phase-training sweep controller. On START it steps the selected PLL
// counter up through NSTEPS positions, qualifies each with SAMPLE_OK,
// finds the longest contiguous passing window, steps back down to its
// centre and reports the result.
// Optional build macro: DYN_PHASE_STEP_TIMEOUT_EN adds a step watchdog
// that aborts the sweep (FAIL=1, ERR=1) if a step is not completed within
// STEP_TIMEOUT cycles of its request. Without it the wait is unbounded and
// ERR is tied low.
// Ports:
//   CLK50M, RESET_N   clock / asynchronous active-low reset
//   START             one-cycle pulse, starts a sweep when idle
//   SAMPLE_OK         checker result, 1 = data good this cycle
//   STEP_DONE         one-cycle completion pulse from the stepper
//   COUNTER           counter select, CNT_SEL while BUSY else 0
//   STEP_REQ/STEP_UP  one-cycle step request and its direction (1 = up)
//   BUSY, DONE        sweep in progress / one-cycle end-of-sweep pulse
//   FAIL, ERR         no passing position or timeout / timeout (held)
//   BEST_POS, WIN_LEN window centre / best window length (held)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for START
// SETTLE    | wait SETTLE_CYC cycles after reaching a position
// SAMPLE    | AND SAMPLE_OK over SAMPLE_CYC cycles
// EVAL      | fold the result into the window tracker
// STEP      | issue one up-step request
// STEPWAIT  | wait for the up-step to complete
// CALC      | compute the window centre
// RETURN    | issue one down-step request
// RETWAIT   | wait for the down-step to complete
// FINISH    | results valid, DONE pulse
module dyn_phase_sweep
    import dyn_phase_pkg::*;
#(
    parameter int         NSTEPS     = 64,
    parameter int         SETTLE_CYC = 16,
    parameter int         SAMPLE_CYC = 256,
    parameter logic [3:0] CNT_SEL    = CNT_SEL_C0
) (
    input  logic       CLK50M,
    input  logic       RESET_N,
    input  logic       START,
    input  logic       SAMPLE_OK,
    input  logic       STEP_DONE,
    output logic [3:0] COUNTER,
    output logic       STEP_REQ,
    output logic       STEP_UP,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic       ERR,
    output logic [7:0] BEST_POS,
    output logic [7:0] WIN_LEN
);

    localparam int TMAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] SAMPLE_LOAD = TW'(SAMPLE_CYC - 1);
    localparam logic [7:0]    LAST_POS    = 8'(NSTEPS - 1);

    sweep_state_t  state;
    logic [TW-1:0] timer;
    logic [7:0]    pos;
    logic [7:0]    target;
    logic          sample_acc;
    logic          step_req;
    logic          step_up;
    logic          busy;
    logic          done;
    logic          fail;
    logic [7:0]    best_pos;
    logic [7:0]    win_len;

    logic          win_clear;
    logic          win_eval;
    logic [7:0]    best_start;
    logic [7:0]    best_len;
    logic [7:0]    centre;

`ifdef DYN_PHASE_STEP_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(STEP_TIMEOUT - 1);
    logic [WD_W-1:0] wd;
    logic            err;
`endif

    assign win_clear = (state == S_IDLE) && START;
    assign win_eval  = (state == S_EVAL);
    assign centre    = (best_len == 8'd0) ? 8'd0 : centre_pos(best_start, best_len);

    dyn_phase_window u_window (
        .clk        (CLK50M),
        .rst_n      (RESET_N),
        .clear      (win_clear),
        .eval       (win_eval),
        .pass       (sample_acc),
        .pos        (pos),
        .best_start (best_start),
        .best_len   (best_len)
    );

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            timer      <= '0;
            pos        <= 8'd0;
            target     <= 8'd0;
            sample_acc <= 1'b0;
            step_req   <= 1'b0;
            step_up    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            best_pos   <= 8'd0;
            win_len    <= 8'd0;
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
            wd         <= '0;
            err        <= 1'b0;
`endif
        end else begin
            step_req <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state    <= S_SETTLE;
                        busy     <= 1'b1;
                        timer    <= SETTLE_LOAD;
                        pos      <= 8'd0;
                        target   <= 8'd0;
                        step_up  <= 1'b0;
                        fail     <= 1'b0;
                        best_pos <= 8'd0;
                        win_len  <= 8'd0;
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
                        err      <= 1'b0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (timer == '0) begin
                        state      <= S_SAMPLE;
                        timer      <= SAMPLE_LOAD;
                        sample_acc <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    sample_acc <= sample_acc & SAMPLE_OK;
                    if (timer == '0) begin
                        state <= S_EVAL;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_EVAL: begin
                    if (pos == LAST_POS) begin
                        state <= S_CALC;
                    end else begin
                        state    <= S_STEP;
                        step_req <= 1'b1;
                        step_up  <= 1'b1;
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
                        wd       <= WD_LOAD;
`endif
                    end
                end
                S_STEP: begin
                    state <= S_STEPWAIT;
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
                    wd    <= wd - 1'b1;
`endif
                end
                S_STEPWAIT: begin
                    if (STEP_DONE) begin
                        pos   <= pos + 8'd1;
                        state <= S_SETTLE;
                        timer <= SETTLE_LOAD;
                    end
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
                    else if (wd == '0) begin
                        state    <= S_FINISH;
                        done     <= 1'b1;
                        fail     <= 1'b1;
                        err      <= 1'b1;
                        best_pos <= pos;
                        win_len  <= best_len;
                    end else begin
                        wd <= wd - 1'b1;
                    end
`endif
                end
                S_CALC: begin
                    target <= centre;
                    if (best_len == 8'd0) begin
                        fail <= 1'b1;
                    end
                    if (pos == centre) begin
                        state    <= S_FINISH;
                        done     <= 1'b1;
                        best_pos <= centre;
                        win_len  <= best_len;
                    end else begin
                        state    <= S_RETURN;
                        step_req <= 1'b1;
                        step_up  <= 1'b0;
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
                        wd       <= WD_LOAD;
`endif
                    end
                end
                S_RETURN: begin
                    state <= S_RETWAIT;
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
                    wd    <= wd - 1'b1;
`endif
                end
                S_RETWAIT: begin
                    if (STEP_DONE) begin
                        pos <= pos - 8'd1;
                        if ((pos - 8'd1) == target) begin
                            state    <= S_FINISH;
                            done     <= 1'b1;
                            best_pos <= target;
                            win_len  <= best_len;
                        end else begin
                            state    <= S_RETURN;
                            step_req <= 1'b1;
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
                            wd       <= WD_LOAD;
`endif
                        end
                    end
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
                    else if (wd == '0) begin
                        state    <= S_FINISH;
                        done     <= 1'b1;
                        fail     <= 1'b1;
                        err      <= 1'b1;
                        best_pos <= pos;
                        win_len  <= best_len;
                    end else begin
                        wd <= wd - 1'b1;
                    end
`endif
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign COUNTER  = busy ? CNT_SEL : CNT_SEL_ALL;
    assign STEP_REQ = step_req;
    assign STEP_UP  = step_up;
    assign BUSY     = busy;
    assign DONE     = done;
    assign FAIL     = fail;
    assign BEST_POS = best_pos;
    assign WIN_LEN  = win_len;
`ifdef DYN_PHASE_STEP_TIMEOUT_EN
    assign ERR      = err;
`else
    assign ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_dyn_phase_sweep.sv
`timescale 1ns/1ps
module tb_dyn_phase_sweep;

    localparam int NSTEPS     = 64;
    localparam int SETTLE_CYC = 2;
    localparam int SAMPLE_CYC = 4;

    logic       CLK50M = 1'b0;
    logic       RESET_N;
    logic       START;
    logic       SAMPLE_OK;
    logic       STEP_DONE;
    logic [3:0] COUNTER;
    logic       STEP_REQ;
    logic       STEP_UP;
    logic       BUSY;
    logic       DONE;
    logic       FAIL;
    logic       ERR;
    logic [7:0] BEST_POS;
    logic [7:0] WIN_LEN;

    dyn_phase_sweep #(
        .NSTEPS     (NSTEPS),
        .SETTLE_CYC (SETTLE_CYC),
        .SAMPLE_CYC (SAMPLE_CYC),
        .CNT_SEL    (4'h2)
    ) dut (
        .CLK50M    (CLK50M),
        .RESET_N   (RESET_N),
        .START     (START),
        .SAMPLE_OK (SAMPLE_OK),
        .STEP_DONE (STEP_DONE),
        .COUNTER   (COUNTER),
        .STEP_REQ  (STEP_REQ),
        .STEP_UP   (STEP_UP),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .FAIL      (FAIL),
        .ERR       (ERR),
        .BEST_POS  (BEST_POS),
        .WIN_LEN   (WIN_LEN)
    );

    always #10 CLK50M = ~CLK50M;

    int cyc = 0;
    always @(posedge CLK50M) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Stepper and training-checker model. Phase is relative to sweep start.
    logic [63:0] pat        = '0;
    bit          drop_en    = 1'b0;
    bit          spur_en    = 1'b0;
    int          withhold_n = 0;
    int          phase      = 0;
    int          up_cnt     = 0;
    int          dn_cnt     = 0;
    int          req_cyc    = 0;
    int          dly        = 0;
    int          since_done = 100;
    bit          sdir       = 1'b0;

    initial begin
        STEP_DONE = 1'b0;
        SAMPLE_OK = 1'b0;
        forever begin
            @(negedge CLK50M);
            STEP_DONE = 1'b0;
            since_done++;
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    STEP_DONE  = 1'b1;
                    phase      = sdir ? phase + 1 : phase - 1;
                    since_done = 0;
                end
            end
            if (STEP_REQ) begin
                if (STEP_UP) up_cnt++;
                else         dn_cnt++;
                req_cyc = cyc;
                sdir    = STEP_UP;
                if (!(withhold_n != 0 && (up_cnt + dn_cnt) == withhold_n))
                    dly = 1;
                // Stray pulse in the request cycle must be ignored.
                if (spur_en) STEP_DONE = 1'b1;
            end
            // Settle occupies done+1..done+2, sampling done+3..done+6.
            if (phase >= 0 && phase < 64)
                SAMPLE_OK = pat[phase] && !(drop_en && phase == 20 && since_done == 4);
            else
                SAMPLE_OK = 1'b0;
        end
    end

    task automatic wait_done(input int bound, input bit mid, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK50M);
            START = (mid && i == 100);
            if (DONE) begin
                seen  = 1'b1;
                START = 1'b0;
                break;
            end
        end
    endtask

    task automatic start_sweep(input logic [63:0] p, input bit drop, input bit spur);
        pat     = p;
        drop_en = drop;
        spur_en = spur;
        phase   = 0;
        up_cnt  = 0;
        dn_cnt  = 0;
        @(negedge CLK50M);
        START = 1'b1;
        @(negedge CLK50M);
        START = 1'b0;
    endtask

    task automatic run_sweep(input string name, input logic [63:0] p,
                             input bit drop, input bit spur, input bit mid,
                             input int exp_best, input int exp_len,
                             input int exp_fail, input int exp_dn);
        bit seen;
        start_sweep(p, drop, spur);
        check_val({name, ".busy_start"}, int'(BUSY), 1);
        check_val({name, ".counter_busy"}, int'(COUNTER), 2);
        wait_done(5000, mid, seen);
        check_val({name, ".done_seen"}, int'(seen), 1);
        if (seen) begin
            check_val({name, ".best_pos"}, int'(BEST_POS), exp_best);
            check_val({name, ".win_len"}, int'(WIN_LEN), exp_len);
            check_val({name, ".fail"}, int'(FAIL), exp_fail);
            check_val({name, ".err"}, int'(ERR), 0);
            check_val({name, ".busy_at_done"}, int'(BUSY), 1);
            check_val({name, ".up_steps"}, up_cnt, NSTEPS - 1);
            check_val({name, ".down_steps"}, dn_cnt, exp_dn);
            check_val({name, ".phase"}, phase, exp_best);
            @(negedge CLK50M);
            check_val({name, ".done_pulse"}, int'(DONE), 0);
            check_val({name, ".busy_after"}, int'(BUSY), 0);
            check_val({name, ".counter_idle"}, int'(COUNTER), 0);
            check_val({name, ".best_held"}, int'(BEST_POS), exp_best);
        end
        spur_en = 1'b0;
        drop_en = 1'b0;
    endtask

    initial begin
        bit seen;
        RESET_N = 1'b1;
        START   = 1'b0;
        #5 RESET_N = 1'b0;
        #1;
        check_val("rst.busy", int'(BUSY), 0);
        check_val("rst.done", int'(DONE), 0);
        check_val("rst.fail", int'(FAIL), 0);
        check_val("rst.err", int'(ERR), 0);
        check_val("rst.step_req", int'(STEP_REQ), 0);
        check_val("rst.counter", int'(COUNTER), 0);
        check_val("rst.best_pos", int'(BEST_POS), 0);
        check_val("rst.win_len", int'(WIN_LEN), 0);
        repeat (2) @(negedge CLK50M);
        RESET_N = 1'b1;

        // Stray STEP_DONE while idle must not start anything.
        @(negedge CLK50M);
        STEP_DONE = 1'b1;
        repeat (3) @(negedge CLK50M);
        check_val("idle.stray_done", int'(BUSY), 0);

        run_sweep("all_pass", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 31, 64, 0, 32);
        run_sweep("win10_19", 64'h0000_0000_000F_FC00, 1'b0, 1'b1, 1'b0, 14, 10, 0, 49);
        run_sweep("tie",      64'h0000_1F00_0000_00F8, 1'b0, 1'b0, 1'b0,  5,  5, 0, 58);
        run_sweep("none",     64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b0,  0,  0, 1, 63);
        run_sweep("drop20",   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 42, 43, 0, 21);

`ifdef DYN_PHASE_STEP_TIMEOUT_EN
        withhold_n = 5;
        start_sweep(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        wait_done(3000, 1'b0, seen);
        check_val("tmo.done_seen", int'(seen), 1);
        if (seen) begin
            check_val("tmo.latency", cyc - req_cyc, 1024);
            check_val("tmo.err", int'(ERR), 1);
            check_val("tmo.fail", int'(FAIL), 1);
            check_val("tmo.best_pos", int'(BEST_POS), 4);
            check_val("tmo.requests", up_cnt, 5);
            @(negedge CLK50M);
            check_val("tmo.busy_after", int'(BUSY), 0);
        end
        withhold_n = 0;
`endif

        // Reset in the middle of a sweep.
        start_sweep(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        repeat (150) @(negedge CLK50M);
        check_val("mid.busy_before", int'(BUSY), 1);
        RESET_N = 1'b0;
        #1;
        check_val("mid.busy", int'(BUSY), 0);
        check_val("mid.counter", int'(COUNTER), 0);
        check_val("mid.step_req", int'(STEP_REQ), 0);
        check_val("mid.done", int'(DONE), 0);
        check_val("mid.fail", int'(FAIL), 0);
        check_val("mid.err", int'(ERR), 0);
        @(negedge CLK50M);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK50M);
        check_val("mid.stays_idle", int'(BUSY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
